// File: rtl/match_referee_if.sv
// Bundle between game logic (master) and the match referee (slave): point pulses in, scores and
// ASCII status out.
interface match_referee_if #(
  parameter int unsigned SCORE_W = 7
);
  logic               start;
  logic               my_point;
  logic               op_point;
  logic [SCORE_W-1:0] my_score;
  logic [SCORE_W-1:0] op_score;
  logic [6:0]         leader;
  logic [6:0]         winner;
  logic               playing;
  logic               game_over;

  modport master (
    output start, my_point, op_point,
    input  my_score, op_score, leader, winner, playing, game_over
  );

  modport slave (
    input  start, my_point, op_point,
    output my_score, op_score, leader, winner, playing, game_over
  );
endinterface

// File: rtl/match_referee.sv
// Two-player match referee: owns both saturating score counters, runs the IDLE/PLAY/OVER FSM and
// publishes leader/winner as ASCII codes for the font ROM.
module match_referee #(
  parameter int unsigned SCORE_W   = 7,
  parameter int unsigned WIN_SCORE = 11,
  parameter int unsigned WIN_BY    = 2
) (
  input  logic            clk,
  input  logic            rst,
  match_referee_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StPlay, StOver} state_e;

  localparam logic [SCORE_W-1:0] ScoreMax   = '1;
  localparam logic [6:0]         AsciiNone  = 7'h30;
  localparam logic [6:0]         AsciiMe    = 7'h31;
  localparam logic [6:0]         AsciiOp    = 7'h32;
  localparam logic [6:0]         AsciiDraw  = 7'h33;
  localparam logic [6:0]         AsciiLevel = 7'h3D;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] my_score_q, my_score_d;
  logic [SCORE_W-1:0] op_score_q, op_score_d;
  logic [6:0]         leader_q, leader_d;
  logic [6:0]         winner_q, winner_d;

  logic [SCORE_W:0]   my_diff, op_diff;
  logic               my_win, op_win, draw;

  // Differences carry an extra bit so a negative lead shows up as a set MSB, not a large lead.
  always_comb begin
    my_diff = {1'b0, my_score_q} - {1'b0, op_score_q};
    op_diff = {1'b0, op_score_q} - {1'b0, my_score_q};
    my_win  = (32'(my_score_q) >= WIN_SCORE) && !my_diff[SCORE_W] && (32'(my_diff) >= WIN_BY);
    op_win  = (32'(op_score_q) >= WIN_SCORE) && !op_diff[SCORE_W] && (32'(op_diff) >= WIN_BY);
    draw    = (my_score_q == ScoreMax) && (op_score_q == ScoreMax) && !my_win && !op_win;
  end

  always_comb begin
    state_d    = state_q;
    my_score_d = my_score_q;
    op_score_d = op_score_q;
    winner_d   = winner_q;

    if (my_score_q > op_score_q) begin
      leader_d = AsciiMe;
    end else if (op_score_q > my_score_q) begin
      leader_d = AsciiOp;
    end else begin
      leader_d = AsciiLevel;
    end

    unique case (state_q)
      StIdle, StOver: begin
        if (bus.start) begin
          state_d    = StPlay;
          my_score_d = '0;
          op_score_d = '0;
          winner_d   = AsciiNone;
        end
      end
      StPlay: begin
        if (bus.start) begin
          my_score_d = '0;
          op_score_d = '0;
          winner_d   = AsciiNone;
        end else if (my_win || op_win || draw) begin
          // Points arriving on the deciding edge are dropped so the final score stays as judged.
          state_d  = StOver;
          winner_d = my_win ? AsciiMe : (op_win ? AsciiOp : AsciiDraw);
        end else if (bus.my_point && !bus.op_point) begin
          if (my_score_q != ScoreMax) my_score_d = my_score_q + 1'b1;
        end else if (bus.op_point && !bus.my_point) begin
          if (op_score_q != ScoreMax) op_score_d = op_score_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      my_score_q <= '0;
      op_score_q <= '0;
      leader_q   <= AsciiLevel;
      winner_q   <= AsciiNone;
    end else begin
      state_q    <= state_d;
      my_score_q <= my_score_d;
      op_score_q <= op_score_d;
      leader_q   <= leader_d;
      winner_q   <= winner_d;
    end
  end

  assign bus.my_score  = my_score_q;
  assign bus.op_score  = op_score_q;
  assign bus.leader    = leader_q;
  assign bus.winner    = winner_q;
  assign bus.playing   = (state_q == StPlay);
  assign bus.game_over = (state_q == StOver);

endmodule
